// File: rtl/score_reader.sv
// score_reader: read-side companion to the per-player score RAM.
// Serves single-player score lookups and full-table scans that report the
// leading player, the leading score and whether that score is tied.
// The read port has a fixed latency of RD_LAT cycles from ram_addr_o to ram_q_i.
// Optional feature: define SCORE_READER_AUTOSCAN_EN to start a scan every
// SCAN_PERIOD cycles without an explicit scan_req_i.

module score_reader #(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 3,
    parameter int NUM_PLAYERS = 5,
    parameter int RD_LAT      = 2,
    parameter int SCAN_PERIOD = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_id_i,
    input  logic              scan_req_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [DATA_W-1:0] ram_q_i,
    output logic              busy_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_score_o,
    output logic              rd_err_o,
    output logic              scan_done_o,
    output logic [ADDR_W-1:0] lead_id_o,
    output logic [DATA_W-1:0] lead_score_o,
    output logic              lead_tie_o
);

    // Wait counter covers the RD_LAT-1 cycles between address and capture.
    localparam int                WAIT_W      = $clog2(RD_LAT + 1);
    localparam int                WAIT_LAST_I = (RD_LAT >= 2) ? RD_LAT - 2 : 0;
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(WAIT_LAST_I);
    localparam logic [ADDR_W-1:0] LAST_ID     = ADDR_W'(NUM_PLAYERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_WAIT,
        RD_CAP,
        SC_ADDR,
        SC_WAIT,
        SC_CAP,
        DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic                busy_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_score_q;
    logic                rd_err_q;
    logic                scan_done_q;
    logic [ADDR_W-1:0]   lead_id_q;
    logic [DATA_W-1:0]   lead_score_q;
    logic                lead_tie_q;

    logic [ADDR_W-1:0]   idx_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [DATA_W-1:0]   sh_max_q, sh_max_d;
    logic [ADDR_W-1:0]   sh_id_q,  sh_id_d;
    logic                sh_tie_q, sh_tie_d;
    logic                scan_start;

`ifdef SCORE_READER_AUTOSCAN_EN
    localparam int                PER_W    = $clog2(SCAN_PERIOD + 1);
    localparam logic [PER_W-1:0]  PER_LAST = PER_W'(SCAN_PERIOD - 1);
    logic [PER_W-1:0]  period_q;
    logic              pending_q;
`endif

    // Scan start source: explicit request, or a pending auto-scan when enabled.
    always_comb begin
`ifdef SCORE_READER_AUTOSCAN_EN
        scan_start = scan_req_i | pending_q;
`else
        scan_start = scan_req_i;
`endif
    end

    // Leader update for the score currently on ram_q_i; lower ID keeps the lead on a tie.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        sh_max_d = sh_max_q;
        sh_id_d  = sh_id_q;
        sh_tie_d = sh_tie_q;
        if (ram_q_i > sh_max_q) begin
            sh_max_d = ram_q_i;
            sh_id_d  = idx_q;
            sh_tie_d = 1'b0;
        end else if (ram_q_i == sh_max_q && idx_q != '0) begin
            sh_tie_d = 1'b1;
        end
    end

    // Control FSM with registered outputs; all state clears on synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ram_addr_q   <= '0;
            busy_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_score_q   <= '0;
            rd_err_q     <= 1'b0;
            scan_done_q  <= 1'b0;
            lead_id_q    <= '0;
            lead_score_q <= '0;
            lead_tie_q   <= 1'b0;
            idx_q        <= '0;
            wait_q       <= '0;
            sh_max_q     <= '0;
            sh_id_q      <= '0;
            sh_tie_q     <= 1'b0;
`ifdef SCORE_READER_AUTOSCAN_EN
            period_q     <= PER_LAST;
            pending_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout; later assignments in
            // this block override the pulse defaults on the same edge.
            rd_valid_q  <= 1'b0;
            scan_done_q <= 1'b0;

`ifdef SCORE_READER_AUTOSCAN_EN
            if (scan_done_q) begin
                period_q <= PER_LAST;
            end else if (period_q == '0) begin
                period_q  <= PER_LAST;
                pending_q <= 1'b1;
            end else begin
                period_q <= period_q - 1'b1;
            end
`endif

            unique case (state_q)
                IDLE: begin
                    if (rd_req_i) begin
                        busy_q <= 1'b1;
                        if (32'(rd_id_i) < NUM_PLAYERS) begin
                            ram_addr_q <= rd_id_i;
                            state_q    <= RD_ADDR;
                        end else begin
                            rd_valid_q <= 1'b1;
                            rd_err_q   <= 1'b1;
                            rd_score_q <= '0;
                            state_q    <= DONE;
                        end
                    end else if (scan_start) begin
                        busy_q     <= 1'b1;
                        idx_q      <= '0;
                        ram_addr_q <= '0;
                        sh_max_q   <= '0;
                        sh_id_q    <= '0;
                        sh_tie_q   <= 1'b0;
                        state_q    <= SC_ADDR;
`ifdef SCORE_READER_AUTOSCAN_EN
                        pending_q  <= 1'b0;
`endif
                    end
                end
                RD_ADDR: begin
                    wait_q  <= '0;
                    state_q <= (RD_LAT == 1) ? RD_CAP : RD_WAIT;
                end
                RD_WAIT: begin
                    if (wait_q == WAIT_LAST) state_q <= RD_CAP;
                    else                     wait_q  <= wait_q + 1'b1;
                end
                RD_CAP: begin
                    rd_score_q <= ram_q_i;
                    rd_err_q   <= 1'b0;
                    rd_valid_q <= 1'b1;
                    state_q    <= DONE;
                end
                SC_ADDR: begin
                    wait_q  <= '0;
                    state_q <= (RD_LAT == 1) ? SC_CAP : SC_WAIT;
                end
                SC_WAIT: begin
                    if (wait_q == WAIT_LAST) state_q <= SC_CAP;
                    else                     wait_q  <= wait_q + 1'b1;
                end
                SC_CAP: begin
                    sh_max_q <= sh_max_d;
                    sh_id_q  <= sh_id_d;
                    sh_tie_q <= sh_tie_d;
                    if (idx_q == LAST_ID) begin
                        lead_id_q    <= sh_id_d;
                        lead_score_q <= sh_max_d;
                        lead_tie_q   <= sh_tie_d;
                        scan_done_q  <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        idx_q      <= idx_q + 1'b1;
                        ram_addr_q <= idx_q + 1'b1;
                        state_q    <= SC_ADDR;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_addr_o   = ram_addr_q;
    assign busy_o       = busy_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_score_o   = rd_score_q;
    assign rd_err_o     = rd_err_q;
    assign scan_done_o  = scan_done_q;
    assign lead_id_o    = lead_id_q;
    assign lead_score_o = lead_score_q;
    assign lead_tie_o   = lead_tie_q;

endmodule
